// File: rtl/mem_map_pkg.sv
// Shared memory-map constants, bus widths and arbiter owner encoding for the
// text/glyph/instruction/stack BRAM.
package mem_map_pkg;

    localparam int unsigned AW_DEF = 15;
    localparam int unsigned DW_DEF = 16;

    // Word-addressed regions of the shared BRAM.
    localparam int unsigned TEXT_BASE   = 0;
    localparam int unsigned TEXT_SIZE   = 4800;
    localparam int unsigned GLYPH_BASE  = 4800;
    localparam int unsigned GLYPH_SIZE  = 4096;
    localparam int unsigned INSTR_BASE  = 9216;
    localparam int unsigned INSTR_SIZE  = 10240;
    localparam int unsigned INPUT_BASE  = 19456;
    localparam int unsigned INPUT_SIZE  = 256;
    localparam int unsigned OUTPUT_BASE = 19712;
    localparam int unsigned OUTPUT_SIZE = 256;
    localparam int unsigned STACK_BASE  = 19968;
    localparam int unsigned STACK_SIZE  = 4096;

    typedef enum logic [1:0] {
        OWN_IDLE       = 2'd0,
        OWN_CORE       = 2'd1,
        OWN_AUX        = 2'd2,
        OWN_AUX_LOCKED = 2'd3
    } owner_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_AUX  = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (core = 0, aux = 1) with a lock override that
// lets requester 1 keep winning under contention.
module rr_arb2
    import mem_map_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic lock1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    req_id_e last_q, last_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        last_d = last_q;
        if (reset) begin
            if (req0_i && req1_i) begin
                if (lock1_i) begin
                    gnt1_o = 1'b1;
                end else if (last_q == REQ_AUX) begin
                    gnt0_o = 1'b1;
                end else begin
                    gnt1_o = 1'b1;
                end
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
        if (gnt0_o) begin
            last_d = REQ_CORE;
        end else if (gnt1_o) begin
            last_d = REQ_AUX;
        end
    end

    // Reset favours the core on the first contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= REQ_AUX;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares BRAM port B between the CPU core and an aux bus master; round-robin
// with bounded aux burst lock. Optional aux write protection: WRITE_PROTECT_EN.
module mem_port_arbiter
    import mem_map_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned PROT_BASE = 9216,
    parameter int unsigned PROT_SIZE = 10240
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          a_req,
    input  logic          a_lock,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    output logic          a_fault,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int unsigned BCW = 8;

`ifdef WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    owner_e          owner_q, owner_d;
    logic [BCW-1:0]  burst_q, burst_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   din_q;
    logic            c_ack_q, a_ack_q, rd_q, fault_q;
    logic [DW-1:0]   c_rdata_q, a_rdata_q;
    logic            lock_ovr_c, a_blocked_c, burst_room_c;

    assign burst_room_c = 32'(burst_q) < MAX_BURST;
    assign lock_ovr_c   = (owner_q == OWN_AUX_LOCKED) && a_lock && burst_room_c;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req0_i  (c_req),
        .req1_i  (a_req),
        .lock1_i (lock_ovr_c),
        .gnt0_o  (c_gnt),
        .gnt1_o  (a_gnt)
    );

    assign a_blocked_c = PROT_EN && a_gnt && a_we
                         && (32'(a_addr) >= PROT_BASE)
                         && (32'(a_addr) < (PROT_BASE + PROT_SIZE));

    // Port-B drive: winner this cycle, otherwise hold the last address/data.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (!reset) begin
            mem_addr = '0;
            mem_din  = '0;
        end else if (c_gnt) begin
            mem_we   = c_we;
            mem_addr = c_addr;
            mem_din  = c_wdata;
        end else if (a_gnt) begin
            mem_we   = a_we && !a_blocked_c;
            mem_addr = a_addr;
            mem_din  = a_wdata;
        end
    end

    // Owner state and burst counter; a locked aux win enters AUX_LOCKED.
    always_comb begin
        owner_d = OWN_IDLE;
        burst_d = burst_q;
        if (c_gnt) begin
            owner_d = OWN_CORE;
        end else if (a_gnt) begin
            owner_d = a_lock ? OWN_AUX_LOCKED : OWN_AUX;
        end
        if (c_gnt || !a_lock) begin
            burst_d = '0;
        end else if (a_gnt && burst_room_c) begin
            burst_d = burst_q + BCW'(1);
        end
    end

    // Responses are gated by reset so an in-flight ack is dropped at once.
    assign c_ack   = c_ack_q && reset;
    assign a_ack   = a_ack_q && reset;
    assign a_fault = fault_q && reset;
    assign c_rdata = (c_ack && rd_q) ? mem_dout : c_rdata_q;
    assign a_rdata = (a_ack && rd_q) ? mem_dout : a_rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q   <= OWN_IDLE;
            burst_q   <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            c_ack_q   <= 1'b0;
            a_ack_q   <= 1'b0;
            rd_q      <= 1'b0;
            fault_q   <= 1'b0;
            c_rdata_q <= '0;
            a_rdata_q <= '0;
        end else begin
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            addr_q    <= mem_addr;
            din_q     <= mem_din;
            c_ack_q   <= c_gnt;
            a_ack_q   <= a_gnt;
            rd_q      <= c_gnt ? !c_we : !a_we;
            fault_q   <= a_blocked_c;
            c_rdata_q <= c_rdata;
            a_rdata_q <= a_rdata;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares port B of the text/glyph/instruction/stack BRAM between two requesters: the CPU core (requester 0) and an auxiliary bus master (requester 1), e.g. a loader or IO copier.
- Sits between the requesters and the memory controller's BRAM port.
- Round-robin arbitration, with optional bounded burst locking for the auxiliary master.
- Tags each granted access and returns read data and acknowledgement to the owning requester one cycle later.

Parameters:
- AW, 15, memory word-address width.
- DW, 16, data width.
- MAX_BURST, 8, maximum consecutive locked grants to aux. Range 1..255.
- PROT_BASE, 9216, first word of the write-protected instruction region.
- PROT_SIZE, 10240, size in words of the write-protected region.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- c_req  in  1  core access request.
- c_we  in  1  core write enable, qualified by c_req.
- c_addr  in  AW  core word address.
- c_wdata  in  DW  core write data.
- c_gnt  out  1  core granted this cycle (combinational).
- c_ack  out  1  core access completed, one cycle after grant.
- c_rdata  out  DW  core read data, valid with c_ack on reads.
- a_req  in  1  aux access request.
- a_lock  in  1  aux requests burst lock.
- a_we  in  1  aux write enable.
- a_addr  in  AW  aux word address.
- a_wdata  in  DW  aux write data.
- a_gnt  out  1  aux granted this cycle (combinational).
- a_ack  out  1  aux access completed, one cycle after grant.
- a_rdata  out  DW  aux read data.
- a_fault  out  1  one-cycle pulse: aux write was blocked (WRITE_PROTECT_EN only).
- mem_we  out  1  BRAM port-B write enable.
- mem_addr  out  AW  BRAM port-B address.
- mem_din  out  DW  BRAM port-B write data.
- mem_dout  in  DW  BRAM port-B read data, registered, one-cycle latency.

Behaviour:
- **Reset** (reset==0 at a clk edge):
  - last_winner=AUX, so the core wins the first contention.
  - burst_cnt=0; owner_q=NONE; c_ack=a_ack=0; a_fault=0.
  - c_gnt and a_gnt are forced to 0 while reset is low.
  - mem_we=0, mem_addr=0, mem_din=0.
- **State:** owner in {IDLE, CORE, AUX, AUX_LOCKED}, registered as the winner of the previous cycle.
- **Arbitration** (combinational, per cycle):
  - Only one requester asserts req: it wins.
  - Both assert req, owner==AUX_LOCKED, a_lock=1, burst_cnt<MAX_BURST: aux wins.
  - Both assert req, otherwise: the requester that is not last_winner wins.
  - Neither asserts req: no grant; mem_we=0; mem_addr/mem_din hold their previous values.
- **Exclusivity:** exactly the winner's gnt is high. c_gnt and a_gnt are never high together.
- **Memory drive:** mem_we/mem_addr/mem_din are driven from the winner in the grant cycle. A requester keeps req/we/addr/wdata stable until it sees gnt; ungranted requests stay pending, with no loss.
- **Response:** in cycle T+1 after a grant in T:
  - The winner's ack pulses for exactly one cycle.
  - On a read, its rdata=mem_dout.
  - On a write, rdata is unchanged.
  - The non-owner's rdata holds its last value.
- **Back-to-back:** a new grant in T+1 is allowed while the T ack is returned. Full throughput is one access per cycle.
- **Transitions:**
  - IDLE/CORE go to CORE or AUX per the winner.
  - AUX goes to AUX_LOCKED when aux wins with a_lock=1.
  - AUX_LOCKED stays while aux wins with a_lock=1. It exits to CORE, AUX or IDLE when a_lock drops, aux stops requesting, or burst_cnt reaches MAX_BURST with c_req high.
- **burst_cnt:**
  - Increments on each locked aux grant, saturating at MAX_BURST.
  - Clears on any core grant, or on any cycle with a_lock=0.
- **Lock limits:** the lock never starves the core beyond MAX_BURST cycles. Lock has no effect when c_req=0.
- **Reset mid-access:** the pending ack is dropped; no ack is issued after reset deasserts.

Optional Feature:
- Macro: WRITE_PROTECT_EN.
- Defined:
  - An aux write with PROT_BASE <= a_addr < PROT_BASE+PROT_SIZE is still granted and consumes the slot, but mem_we=0.
  - a_ack pulses at T+1, together with a_fault=1 for one cycle.
  - Core writes are never blocked.
- Undefined: all writes pass through, and a_fault is tied to 0.

Decomposition:
- Shared package (mem_map_pkg):
  - Memory-map constants: text, glyph, instr, input, output and stack base/size.
  - Owner-state encoding, as a 2-bit typedef.
  - AW/DW defaults.
- Natural sub-module: rr_arb2, a two-way round-robin with last_winner and a lock override.
- Response tagging and the protect check stay in the top level.

Test Plan:
- Core read alone: c_req=1, c_addr=0x0010, mem holds 0xBEEF -> c_gnt at T, c_ack=1 and c_rdata=0xBEEF at T+1, a_ack=0.
- Contention after reset: both reading, c_addr=0x0001, a_addr=0x0002 -> core granted first, aux the next cycle; acks alternate, each holding its own address's data.
- Burst lock: MAX_BURST=4, a_lock=1, aux streaming writes 0x6000..0x6007, c_req constantly high -> aux gets 4 grants, core 1, then aux 4 again; no starvation.
- Back-to-back: core reads 0x0100 then writes 0x0101=0x1234 on consecutive cycles -> two acks on consecutive cycles; a readback of 0x0101 returns 0x1234.
- WRITE_PROTECT_EN: aux writes 0x5555 to address 9300 -> mem_we=0, a_ack and a_fault pulse at T+1; a core read of 9300 returns the original value.
- Reset mid-access: reset=0 in the cycle after a grant -> no ack, gnts 0; after release the core wins the first contention.
